fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_pkg.sv | 15 +
 rtl/fifo_stream_skid.sv | 71 +++++++
 rtl/fifo_stream_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and sizing for the FIFO-to-stream burst reader.
package fifo_stream_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry skid buffer. The head register drives the stream outputs directly,
// so downstream never sees the FIFO read bus combinationally.
module fifo_stream_skid
  import fifo_stream_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [OCC_WIDTH-1:0]  occ_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic                  rd;

  assign rd = rd_en_i & (occ_q != '0);

  // Keep the oldest word in head; a simultaneous write and read shifts tail forward.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({wr_en_i, rd})
      2'b10: begin
        if (occ_q == '0) begin
          head_d = wr_data_i;
          occ_d  = occ_q + OCC_WIDTH'(1);
        end else if (occ_q == OCC_WIDTH'(1)) begin
          tail_d = wr_data_i;
          occ_d  = occ_q + OCC_WIDTH'(1);
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - OCC_WIDTH'(1);
      end
      2'b11: begin
        if (occ_q == OCC_WIDTH'(1)) begin
          head_d = wr_data_i;
        end else begin
          head_d = tail_q;
          tail_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a burst of words from a one-cycle-latency FIFO read port and presents
// them as a valid/ready stream with a last marker and a done pulse.
//
//   state  | meaning
//   IDLE   | waiting for Start_In
//   STREAM | popping FIFO and streaming words until the last one handshakes
//   DONE   | one-cycle completion pulse, then back to IDLE
module fifo_stream_reader
  import fifo_stream_pkg::*;
(
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] FIFO_Data_In,
  input  logic                  FIFO_Empty_In,
  output logic                  FIFO_Read_Enable_Out,
  input  logic                  Start_In,
  input  logic [LEN_WIDTH-1:0]  Burst_Length_In,
  output logic [DATA_WIDTH-1:0] M_Data_Out,
  output logic                  M_Valid_Out,
  input  logic                  M_Ready_In,
  output logic                  M_Last_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] req_q, req_d;
  logic [LEN_WIDTH-1:0] sent_q, sent_d;
  logic                 inflight_q;

  logic [OCC_WIDTH-1:0]  skid_occ;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  xfer;
  logic                  last_word;
  logic                  pop;
  logic [OCC_WIDTH:0]    committed;

  assign xfer      = skid_valid & M_Ready_In;
  assign last_word = ((sent_q + LEN_WIDTH'(1)) == len_q);

  // Slots spoken for once this cycle's drain is credited; counting the word
  // leaving this cycle is what lets the reader sustain one word per cycle.
  assign committed = {1'b0, skid_occ} - {{OCC_WIDTH{1'b0}}, xfer}
                   + {{OCC_WIDTH{1'b0}}, inflight_q};

  assign pop = (state_q == STREAM) & ~FIFO_Empty_In & (req_q < len_q)
             & (committed < (OCC_WIDTH + 1)'(SKID_DEPTH));

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req_d   = req_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          len_d   = Burst_Length_In;
          req_d   = '0;
          sent_d  = '0;
          state_d = (Burst_Length_In == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (pop) req_d = req_q + LEN_WIDTH'(1);
        if (xfer) begin
          sent_d = sent_q + LEN_WIDTH'(1);
          if (last_word) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the pop-in-flight flag; reset drops any outstanding pop.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q    <= IDLE;
      len_q      <= '0;
      req_q      <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_q      <= req_d;
      sent_q     <= sent_d;
      inflight_q <= pop;
    end
  end

  fifo_stream_skid u_skid (
    .clk_i     (Clk_In),
    .rst_i     (Reset_In),
    .wr_en_i   (inflight_q),
    .wr_data_i (FIFO_Data_In),
    .rd_en_i   (xfer),
    .data_o    (skid_data),
    .valid_o   (skid_valid),
    .occ_o     (skid_occ)
  );

  assign FIFO_Read_Enable_Out = pop;
  assign M_Data_Out           = skid_data;
  assign M_Valid_Out          = skid_valid;
  assign M_Last_Out           = skid_valid & last_word;
  assign Busy_Out             = (state_q != IDLE);
  assign Done_Out             = (state_q == DONE);

endmodule
